// File: rtl/cache_pkg.sv
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared FSM encoding and helper functions for the cache
//                way-select controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int c_max_ways = 16;
    localparam int c_idx_w    = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WBACK  = 3'd2,
        S_WTHRU  = 3'd3,
        S_FILL   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [c_max_ways-1:0] onehot(input logic [c_idx_w-1:0] idx);
        logic [c_max_ways-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Scans downward so the lowest set bit is the one left standing.
    function automatic logic [c_idx_w-1:0] lowest_bit(input logic [c_max_ways-1:0] v);
        logic [c_idx_w-1:0] r;
        r = '0;
        for (int i = c_max_ways - 1; i >= 0; i--) begin
            if (v[i]) r = c_idx_w'(i);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_lru_ages.sv
// ============================================================================
//  Module      : cache_lru_ages
//  Description : Per-set LRU age array (0 = MRU, WAYS-1 = LRU) with victim
//                read port and single update port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_lru_ages
    import cache_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int SETS   = 4,
    parameter int WAY_W  = clog2(WAYS),
    parameter int SET_IW = (clog2(SETS) > 0) ? clog2(SETS) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [SET_IW-1:0] rd_set,
    output logic [WAY_W-1:0]  victim,
    input  logic              upd_en,
    input  logic [SET_IW-1:0] upd_set,
    input  logic [WAY_W-1:0]  upd_way
);

    logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] r_age;

    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_age[rd_set][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
        end
    end

    // Ways younger than the touched way age by one; the permutation is kept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
        end else if (upd_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == upd_way) begin
                    r_age[upd_set][w] <= '0;
                end else if (r_age[upd_set][w] < r_age[upd_set][upd_way]) begin
                    r_age[upd_set][w] <= r_age[upd_set][w] + WAY_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_way_ctrl.sv
// ============================================================================
//  Module      : cache_way_ctrl
//  Description : N-way cache way-select / write-enable controller with LRU
//                replacement and RAM fill / write-back sequencing.
//                CACHE_WRITEBACK_EN selects write-back (else write-through).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_way_ctrl
    import cache_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int SETS   = 4,
    parameter int ADDR_W = 7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic [ADDR_W-1:0] lk_addr,
    input  logic [WAYS-1:0]   hit,
    input  logic [WAYS-1:0]   valid,
    input  logic [WAYS-1:0]   dirty,
    output logic [WAYS-1:0]   way_wren,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_ack,
    output logic              resp_valid,
    output logic              resp_hit
);

    localparam int c_way_w  = clog2(WAYS);
    localparam int c_set_w  = clog2(SETS);
    localparam int c_set_iw = (c_set_w > 0) ? c_set_w : 1;

    state_t               r_state;
    logic                 r_wr;
    logic                 r_hit;
    logic [c_way_w-1:0]   r_sel;

    logic [c_set_iw-1:0]  w_set;
    logic [c_way_w-1:0]   w_victim;
    logic [c_way_w-1:0]   w_sel;
    logic                 w_any_hit;
    logic                 w_any_free;
    logic                 w_need_wb;
    logic                 w_upd_en;
    logic [c_max_ways-1:0] w_hit_x;
    logic [c_max_ways-1:0] w_free_x;

    generate
        if (c_set_w == 0) begin : g_one_set
            assign w_set = '0;
        end else begin : g_multi_set
            assign w_set = lk_addr[c_set_w-1:0];
        end
    endgenerate

`ifdef CACHE_WRITEBACK_EN
    localparam bit c_write_through = 1'b0;
    assign w_need_wb = !w_any_hit && !w_any_free && dirty[w_victim];
`else
    localparam bit c_write_through = 1'b1;
    logic w_unused_dirty;
    assign w_unused_dirty = ^dirty;
    assign w_need_wb      = 1'b0;
`endif

    cache_lru_ages #(
        .WAYS   (WAYS),
        .SETS   (SETS),
        .WAY_W  (c_way_w),
        .SET_IW (c_set_iw)
    ) u_lru (
        .clock   (clock),
        .reset_n (reset_n),
        .rd_set  (w_set),
        .victim  (w_victim),
        .upd_en  (w_upd_en),
        .upd_set (w_set),
        .upd_way (r_sel)
    );

    assign w_upd_en   = (r_state == S_DONE);
    assign w_hit_x    = c_max_ways'(hit);
    assign w_free_x   = c_max_ways'(~valid);
    assign w_any_hit  = |hit;
    assign w_any_free = ~&valid;

    // Priority: hit, then first empty way, then LRU victim.
    always_comb begin
        if (w_any_hit) begin
            w_sel = c_way_w'(lowest_bit(w_hit_x));
        end else if (w_any_free) begin
            w_sel = c_way_w'(lowest_bit(w_free_x));
        end else begin
            w_sel = w_victim;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wr       <= 1'b0;
            r_hit      <= 1'b0;
            r_sel      <= '0;
            req_ready  <= 1'b1;
            lk_addr    <= '0;
            way_wren   <= '0;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
        end else begin
            way_wren   <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        lk_addr   <= req_addr;
                        r_wr      <= req_wr;
                        req_ready <= 1'b0;
                        r_state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_sel <= w_sel;
                    r_hit <= w_any_hit;
                    if (c_write_through && r_wr) begin
                        r_state <= S_WTHRU;
                    end else if (w_any_hit) begin
                        r_state <= S_DONE;
                    end else if (w_need_wb) begin
                        r_state <= S_WBACK;
                    end else begin
                        r_state <= S_FILL;
                    end
                end
                // Each RAM state raises its own request, so back-to-back
                // transactions are separated by an idle ram_req cycle.
                S_WBACK, S_WTHRU, S_FILL: begin
                    if (!ram_req) begin
                        ram_req  <= 1'b1;
                        ram_we   <= (r_state != S_FILL);
                        ram_addr <= lk_addr;
                    end else if (ram_ack) begin
                        ram_req <= 1'b0;
                        ram_we  <= 1'b0;
                        if (r_state == S_WBACK) begin
                            r_state <= S_FILL;
                        end else if (r_state == S_WTHRU && r_hit) begin
                            r_state <= S_DONE;
                        end else if (r_state == S_WTHRU) begin
                            r_state <= S_FILL;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    way_wren   <= (r_wr || !r_hit) ? WAYS'(onehot(c_idx_w'(r_sel))) : '0;
                    resp_valid <= 1'b1;
                    resp_hit   <= r_hit;
                    req_ready  <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_way_ctrl.sv
// ============================================================================
//  Module      : tb_cache_way_ctrl
//  Description : Self-checking bench for cache_way_ctrl against an MRU-list
//                reference model; honours CACHE_WRITEBACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_way_ctrl;

    localparam int WAYS   = 4;
    localparam int SETS   = 4;
    localparam int ADDR_W = 7;

    logic              clock     = 1'b0;
    logic              reset_n   = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_wr    = 1'b0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic              req_ready;
    logic [ADDR_W-1:0] lk_addr;
    logic [WAYS-1:0]   hit       = '0;
    logic [WAYS-1:0]   valid     = '0;
    logic [WAYS-1:0]   dirty     = '0;
    logic [WAYS-1:0]   way_wren;
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_ack   = 1'b0;
    logic              resp_valid;
    logic              resp_hit;

    always #5 clock = ~clock;

    cache_way_ctrl #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .lk_addr    (lk_addr),
        .hit        (hit),
        .valid      (valid),
        .dirty      (dirty),
        .way_wren   (way_wren),
        .ram_req    (ram_req),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_ack    (ram_ack),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: per-set list of ways, most recently used first.
    int order [SETS][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            order[s].delete();
            for (int w = 0; w < WAYS; w++) order[s].push_back(w);
        end
    endfunction

    function automatic int model_pos(input int s, input int w);
        for (int i = 0; i < order[s].size(); i++) if (order[s][i] == w) return i;
        return -1;
    endfunction

    function automatic int model_sel(input int s, input logic [3:0] h, input logic [3:0] v);
        for (int w = 0; w < WAYS; w++) if (h[w]) return w;
        for (int w = 0; w < WAYS; w++) if (!v[w]) return w;
        return order[s][order[s].size()-1];
    endfunction

    function automatic void model_touch(input int s, input int w);
        int p;
        p = model_pos(s, w);
        order[s].delete(p);
        order[s].push_front(w);
    endfunction

    task automatic check_ages();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                check($sformatf("age[%0d][%0d]", s, w), 32'(dut.u_lru.r_age[s][w]), model_pos(s, w));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        req_valid = 1'b0;
        ram_ack   = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", req_ready, 1);
        check("rst_ram_req", ram_req, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_way_wren", way_wren, 0);
        check("rst_lk_addr", lk_addr, 0);
        reset_n = 1'b1;
        model_reset();
    endtask

    // Runs one request from the current negedge until its response.
    task automatic run_txn(input logic [6:0] addr, input logic wr, input logic [3:0] h,
                           input logic [3:0] v, input logic [3:0] d, input int ack_dly,
                           output logic [3:0] o_wren, output int o_lat);
        int s, sel, op_i, cnt, cyc;
        int ops[$];
        bit miss, in_req, acked, done;
        logic [3:0] exp_wren;
        s    = int'(addr) % SETS;
        miss = (h == 4'h0);
        sel  = model_sel(s, h, v);
`ifdef CACHE_WRITEBACK_EN
        if (miss && v == 4'hF && d[sel]) ops.push_back(1);
`else
        if (wr) ops.push_back(1);
`endif
        if (miss) ops.push_back(0);
        exp_wren = (wr || miss) ? 4'(1 << sel) : 4'h0;

        check("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_wr = wr; req_addr = addr;
        hit = h; valid = v; dirty = d; ram_ack = 1'b0;
        op_i = 0; cnt = 0; in_req = 0; acked = 0; done = 0; cyc = 0;
        o_wren = 'x; o_lat = -1;
        while (!done && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (resp_valid) begin
                done   = 1;
                o_wren = way_wren;
                o_lat  = cyc;
                check("resp_hit", resp_hit, !miss);
                check("way_wren", way_wren, exp_wren);
                check("ram_ops", op_i, ops.size());
                check("ready_after", req_ready, 1);
                if (ops.size() == 0) check("hit_latency", cyc, 3);
            end else begin
                check("wren_quiet", way_wren, 0);
                check("ready_busy", req_ready, 0);
            end
            check("lk_addr", lk_addr, addr);
            ram_ack = 1'b0;
            if (acked) begin
                check("ram_req_drop", ram_req, 0);
                acked = 0;
            end else if (ram_req) begin
                if (!in_req) begin
                    in_req = 1;
                    cnt    = 0;
                    check("ram_count", op_i < ops.size(), 1);
                end
                if (op_i < ops.size()) check("ram_we", ram_we, ops[op_i]);
                check("ram_addr", ram_addr, addr);
                if (cnt == ack_dly) begin
                    ram_ack = 1'b1;
                    in_req  = 0;
                    acked   = 1;
                    op_i++;
                end
                cnt++;
            end else if (!done) begin
                ram_ack = 1'($urandom_range(0, 1));
            end
            // Busy-time noise: a stray request and changed lookup inputs.
            if (!done) begin
                req_valid = 1'($urandom_range(0, 1));
                req_wr    = 1'($urandom_range(0, 1));
                req_addr  = 7'($urandom);
                if (cyc >= 2) begin
                    hit = 4'($urandom); valid = 4'($urandom); dirty = 4'($urandom);
                end
            end
        end
        check("no_timeout", done, 1);
        req_valid = 1'b0;
        ram_ack   = 1'b0;
        if (done) model_touch(s, sel);
        check_ages();
    endtask

    initial begin
        logic [3:0] wren;
        int lat;
        bit seen;

        do_reset();
        check_ages();
        check("age_reset_w3", 32'(dut.u_lru.r_age[1][3]), 3);

        // Read hit on way 2 of set 1.
        run_txn(7'h05, 1'b0, 4'b0100, 4'hF, 4'h0, 0, wren, lat);
        check("rd_hit_lat", lat, 3);
        check("rd_hit_wren", wren, 4'b0000);
        check("rd_hit_age2", 32'(dut.u_lru.r_age[1][2]), 0);
        check("rd_hit_age0", 32'(dut.u_lru.r_age[1][0]), 1);
        check("rd_hit_age3", 32'(dut.u_lru.r_age[1][3]), 3);

        // Write hit on way 1.
        run_txn(7'h09, 1'b1, 4'b0010, 4'hF, 4'hF, 1, wren, lat);
        check("wr_hit_wren", wren, 4'b0010);

        // Read miss with way 2 free, slow RAM.
        run_txn(7'h02, 1'b0, 4'b0000, 4'b1011, 4'h0, 5, wren, lat);
        check("miss_free_wren", wren, 4'b0100);

        // Miss on full set with dirty LRU way after a fresh reset.
        do_reset();
        run_txn(7'h03, 1'b0, 4'b0000, 4'hF, 4'b1000, 2, wren, lat);
        check("miss_dirty_wren", wren, 4'b1000);

        // Touch ways 0..3 in set 0, then a full miss evicts way 0.
        for (int w = 0; w < WAYS; w++) begin
            run_txn(7'h10, 1'b0, 4'(1 << w), 4'hF, 4'h0, 0, wren, lat);
        end
        run_txn(7'h20, 1'b0, 4'h0, 4'hF, 4'h0, 1, wren, lat);
        check("evict_way0", wren, 4'b0001);

        // Reset during FILL.
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 7'h21;
        hit = 4'h0; valid = 4'b0111; dirty = 4'h0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (ram_req) seen = 1;
        end
        check("reach_fill", seen, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_ram_req", ram_req, 0);
        check("async_resp", resp_valid, 0);
        check("async_wren", way_wren, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        check("ready_post_rst", req_ready, 1);
        check_ages();
        run_txn(7'h21, 1'b0, 4'h0, 4'b0111, 4'h0, 0, wren, lat);
        check("post_rst_fill", wren, 4'b1000);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic [6:0] a;
            logic [3:0] h, v, d;
            a = 7'($urandom);
            h = ($urandom_range(0, 3) < 2) ? 4'($urandom_range(1, 15)) : 4'h0;
            v = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            d = 4'($urandom);
            run_txn(a, 1'($urandom_range(0, 1)), h, v, d, $urandom_range(0, 4), wren, lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
